// File: rtl/fft_stage_sequencer.sv
`timescale 1ns/1ps
// fft_stage_sequencer
//   Address and stage sequencer for an in-place radix-2 FFT over a two-bank
//   memory holding four 32-bit samples per word. Each stage issues one read
//   of two word addresses per cycle. The matching write-back of the butterfly
//   result is the same address pair delayed by PIPE_LAT cycles. Between
//   stages the sequencer drains the pipeline. This means every write of
//   stage s lands before the first read of stage s+1.
//
//   Every output is a register that shows the state of the current cycle.
//   The next-state logic therefore works out the outputs for the next state
//   one cycle ahead. A stall sampled on a clock edge freezes all sequencing
//   state and the write delay line. Read and write enables are low for the
//   cycle after that edge.
//
// Ports
//   i_CLK           clock, all state on the rising edge
//   i_RESET         synchronous active-high reset, highest priority
//   i_START         single-cycle transform request (accepted only in IDLE)
//   i_LOG2_POINTS   log2 of transform size P, sampled when a start is accepted
//   i_STALL         freeze request from memory/datapath
//   o_BUSY          transform in progress (RUN, DRAIN, DONE)
//   o_DONE          one-cycle completion pulse
//   o_STAGE         current stage index s
//   o_STRIDE        butterfly stride 2^s (0 when idle)
//   o_READ_EN       read issue strobe
//   o_READ_ADDR1/2  word addresses of the two read operands
//   o_WRITE_EN      write-back strobe (read strobe delayed PIPE_LAT cycles)
//   o_WRITE_ADDR1/2 write-back word addresses
module fft_stage_sequencer #(
  parameter int LOG2N    = 10,
  parameter int PIPE_LAT = 2,
  localparam int AW      = LOG2N - 2
) (
  input  logic          i_CLK,
  input  logic          i_RESET,
  input  logic          i_START,
  input  logic [3:0]    i_LOG2_POINTS,
  input  logic          i_STALL,
  output logic          o_BUSY,
  output logic          o_DONE,
  output logic [3:0]    o_STAGE,
  output logic [9:0]    o_STRIDE,
  output logic          o_READ_EN,
  output logic [AW-1:0] o_READ_ADDR1,
  output logic [AW-1:0] o_READ_ADDR2,
  output logic          o_WRITE_EN,
  output logic [AW-1:0] o_WRITE_ADDR1,
  output logic [AW-1:0] o_WRITE_ADDR2
);

  localparam int AW1 = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // First operand address for read index k in stage s. Stages 0 and 1 use
  // adjacent words. Later stages pair words 2^(s-2) apart: a zero is
  // inserted at bit w = s-2 of k, and the bits above it move up one place.
  function automatic logic [AW-1:0] f_addr1(input logic [3:0] s,
                                            input logic [AW-1:0] k);
    logic [AW:0] kk;
    logic [AW:0] lo_mask;
    if (s < 4'd2) return {k[AW-2:0], 1'b0};
    kk      = {1'b0, k};
    lo_mask = (AW1'(1) << (s - 4'd2)) - AW1'(1);
    return AW'(((kk & ~lo_mask) << 1) | (kk & lo_mask));
  endfunction

  function automatic logic [AW-1:0] f_addr2(input logic [3:0] s,
                                            input logic [AW-1:0] a1);
    if (s < 4'd2) return a1 | AW'(1);
    return a1 + (AW'(1) << (s - 4'd2));
  endfunction

  state_t        r_state;
  logic [3:0]    r_s;
  logic [AW-1:0] r_k;
  logic [2:0]    r_cnt;
  logic [3:0]    r_p;

  state_t        w_nx_state;
  logic [3:0]    w_nx_s;
  logic [AW-1:0] w_nx_k;
  logic [2:0]    w_nx_cnt;
  logic [3:0]    w_nx_p;

  logic          w_p_ok;
  logic [AW-1:0] w_k_last;
  logic [2:0]    w_drain_last;
  logic          w_nx_rd_en;
  logic [AW-1:0] w_nx_a1;
  logic [AW-1:0] w_nx_a2;

  // Write-back delay line: entry 0 is loaded alongside the read outputs.
  // The output registers take the oldest entry, PIPE_LAT edges later.
  logic          r_dly_en [PIPE_LAT];
  logic [AW-1:0] r_dly_a1 [PIPE_LAT];
  logic [AW-1:0] r_dly_a2 [PIPE_LAT];

  assign w_p_ok       = (i_LOG2_POINTS >= 4'd3) && (i_LOG2_POINTS <= 4'(LOG2N));
  assign w_k_last     = (AW'(1) << (r_p - 4'd3)) - AW'(1);
  assign w_drain_last = 3'(PIPE_LAT - 1);

  always_comb begin
    w_nx_state = r_state;
    w_nx_s     = r_s;
    w_nx_k     = r_k;
    w_nx_cnt   = r_cnt;
    w_nx_p     = r_p;
    case (r_state)
      S_IDLE: begin
        if (i_START && w_p_ok) begin
          w_nx_state = S_RUN;
          w_nx_s     = 4'd0;
          w_nx_k     = '0;
          w_nx_cnt   = 3'd0;
          w_nx_p     = i_LOG2_POINTS;
        end
      end
      S_RUN: begin
        if (r_k == w_k_last) begin
          w_nx_state = S_DRAIN;
          w_nx_cnt   = 3'd0;
        end else begin
          w_nx_k = r_k + AW'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == w_drain_last) begin
          if (r_s == r_p - 4'd1) begin
            w_nx_state = S_DONE;
          end else begin
            w_nx_state = S_RUN;
            w_nx_s     = r_s + 4'd1;
            w_nx_k     = '0;
          end
        end else begin
          w_nx_cnt = r_cnt + 3'd1;
        end
      end
      S_DONE: begin
        w_nx_state = S_IDLE;
        w_nx_s     = 4'd0;
        w_nx_k     = '0;
      end
      default: begin
        w_nx_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_nx_rd_en = (w_nx_state == S_RUN);
    w_nx_a1    = '0;
    w_nx_a2    = '0;
    if (w_nx_rd_en) begin
      w_nx_a1 = f_addr1(w_nx_s, w_nx_k);
      w_nx_a2 = f_addr2(w_nx_s, w_nx_a1);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state       <= S_IDLE;
      r_s           <= 4'd0;
      r_k           <= '0;
      r_cnt         <= 3'd0;
      r_p           <= 4'd0;
      o_BUSY        <= 1'b0;
      o_DONE        <= 1'b0;
      o_STAGE       <= 4'd0;
      o_STRIDE      <= 10'd0;
      o_READ_EN     <= 1'b0;
      o_READ_ADDR1  <= '0;
      o_READ_ADDR2  <= '0;
      o_WRITE_EN    <= 1'b0;
      o_WRITE_ADDR1 <= '0;
      o_WRITE_ADDR2 <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_dly_en[i] <= 1'b0;
        r_dly_a1[i] <= '0;
        r_dly_a2[i] <= '0;
      end
    end else if (i_STALL) begin
      // Sequencing state and delay line hold; only the strobes drop.
      o_READ_EN  <= 1'b0;
      o_WRITE_EN <= 1'b0;
      o_DONE     <= 1'b0;
    end else begin
      r_state       <= w_nx_state;
      r_s           <= w_nx_s;
      r_k           <= w_nx_k;
      r_cnt         <= w_nx_cnt;
      r_p           <= w_nx_p;
      o_BUSY        <= (w_nx_state != S_IDLE);
      o_DONE        <= (w_nx_state == S_DONE);
      o_STAGE       <= w_nx_s;
      o_STRIDE      <= (w_nx_state == S_IDLE) ? 10'd0 : (10'd1 << w_nx_s);
      o_READ_EN     <= w_nx_rd_en;
      o_READ_ADDR1  <= w_nx_a1;
      o_READ_ADDR2  <= w_nx_a2;
      // pipeline stage boundary: read issue -> write-back delay line
      r_dly_en[0]   <= w_nx_rd_en;
      r_dly_a1[0]   <= w_nx_a1;
      r_dly_a2[0]   <= w_nx_a2;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dly_en[i] <= r_dly_en[i-1];
        r_dly_a1[i] <= r_dly_a1[i-1];
        r_dly_a2[i] <= r_dly_a2[i-1];
      end
      o_WRITE_EN    <= r_dly_en[PIPE_LAT-1];
      o_WRITE_ADDR1 <= r_dly_a1[PIPE_LAT-1];
      o_WRITE_ADDR2 <= r_dly_a2[PIPE_LAT-1];
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  localparam int LOG2N = 10;
  localparam int L     = 2;
  localparam int AW    = LOG2N - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    lp;
  logic          stall;
  logic          busy;
  logic          done;
  logic [3:0]    stage;
  logic [9:0]    stride;
  logic          rd_en;
  logic [AW-1:0] rd_a1;
  logic [AW-1:0] rd_a2;
  logic          wr_en;
  logic [AW-1:0] wr_a1;
  logic [AW-1:0] wr_a2;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.LOG2N(LOG2N), .PIPE_LAT(L)) dut (
    .i_CLK(clk),
    .i_RESET(rst),
    .i_START(start),
    .i_LOG2_POINTS(lp),
    .i_STALL(stall),
    .o_BUSY(busy),
    .o_DONE(done),
    .o_STAGE(stage),
    .o_STRIDE(stride),
    .o_READ_EN(rd_en),
    .o_READ_ADDR1(rd_a1),
    .o_READ_ADDR2(rd_a2),
    .o_WRITE_EN(wr_en),
    .o_WRITE_ADDR1(wr_a1),
    .o_WRITE_ADDR2(wr_a2)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [3:0]    stg;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_wr[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Expected read/write events for a transform started in cycle 0.
  // Stage s reads every word pair (i, i+d) with d=1 for s<=1, else d=2^(s-2).
  // The reads run in ascending i on consecutive cycles, and each write trails
  // its read by L cycles. L drain cycles separate the stages. A stall held
  // during cycles sx..sx+sn-1 pushes every event after cycle sx back by sn.
  task automatic build_expect(input int p, input int sx, input int sn,
                              output int done_c);
    int  t;
    int  kc;
    int  d;
    int  tr;
    int  tw;
    ev_t e;
    q_rd.delete();
    q_wr.delete();
    t = 1;
    for (int s = 0; s < p; s++) begin
      kc = 0;
      d  = (s <= 1) ? 1 : (1 << (s - 2));
      for (int i = 0; i < (1 << (p - 2)); i++) begin
        if ((i & d) == 0) begin
          tr = t + kc;
          tw = tr + L;
          if (sn > 0 && tr > sx) tr += sn;
          if (sn > 0 && tw > sx) tw += sn;
          e.a1  = AW'(i);
          e.a2  = AW'(i + d);
          e.stg = 4'(s);
          e.cyc = tr;
          q_rd.push_back(e);
          e.cyc = tw;
          q_wr.push_back(e);
          kc++;
        end
      end
      t = t + kc + L;
    end
    done_c = t;
    if (sn > 0 && done_c > sx) done_c += sn;
  endtask

  // Runs one full transform and compares every output cycle by cycle.
  // pa/pb: cycles in which a (to-be-ignored) extra start is pulsed.
  task automatic run_transform(input string name, input int p, input int sx,
                               input int sn, input int pa, input int pb);
    int   done_c;
    logic exp_en;
    ev_t  e;
    build_expect(p, sx, sn, done_c);
    @(negedge clk);
    lp    = 4'(p);
    start = 1'b1;
    for (int c = 1; c <= done_c + 3; c++) begin
      @(negedge clk);
      start = (c == pa) || (c == pb);
      stall = (sn > 0) && (c >= sx) && (c < sx + sn);

      exp_en = (q_rd.size() > 0) && (q_rd[0].cyc == c);
      n_checks++;
      if (rd_en !== exp_en) begin
        n_errors++;
        $display("FAIL %s rd_en c%0d got %0b exp %0b", name, c, rd_en, exp_en);
      end
      if (exp_en) begin
        e = q_rd.pop_front();
        n_checks++;
        if (rd_a1 !== e.a1 || rd_a2 !== e.a2) begin
          n_errors++;
          $display("FAIL %s rd_addr c%0d got (%0d,%0d) exp (%0d,%0d)",
                   name, c, rd_a1, rd_a2, e.a1, e.a2);
        end
        n_checks++;
        if (stage !== e.stg || stride !== (10'd1 << e.stg)) begin
          n_errors++;
          $display("FAIL %s stage/stride c%0d got %0d/%0d exp %0d/%0d",
                   name, c, stage, stride, e.stg, 10'd1 << e.stg);
        end
      end

      exp_en = (q_wr.size() > 0) && (q_wr[0].cyc == c);
      n_checks++;
      if (wr_en !== exp_en) begin
        n_errors++;
        $display("FAIL %s wr_en c%0d got %0b exp %0b", name, c, wr_en, exp_en);
      end
      if (exp_en) begin
        e = q_wr.pop_front();
        n_checks++;
        if (wr_a1 !== e.a1 || wr_a2 !== e.a2) begin
          n_errors++;
          $display("FAIL %s wr_addr c%0d got (%0d,%0d) exp (%0d,%0d)",
                   name, c, wr_a1, wr_a2, e.a1, e.a2);
        end
      end

      n_checks++;
      if (busy !== (c <= done_c)) begin
        n_errors++;
        $display("FAIL %s busy c%0d got %0b exp %0b", name, c, busy, c <= done_c);
      end
      n_checks++;
      if (done !== (c == done_c)) begin
        n_errors++;
        $display("FAIL %s done c%0d got %0b exp %0b", name, c, done, c == done_c);
      end
    end
    n_checks++;
    if (q_rd.size() != 0 || q_wr.size() != 0) begin
      n_errors++;
      $display("FAIL %s leftover got rd=%0d wr=%0d exp 0/0",
               name, q_rd.size(), q_wr.size());
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    lp    = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, stage, stride, rd_en, rd_a1, rd_a2, wr_en, wr_a1, wr_a2} !== '0) begin
      n_errors++;
      $display("FAIL reset_state got busy=%0b done=%0b stage=%0d stride=%0d rd=%0b wr=%0b exp all 0",
               busy, done, stage, stride, rd_en, wr_en);
    end
  endtask

  task automatic test_bad_size();
    int sizes[2];
    sizes[0] = 2;
    sizes[1] = 11;
    foreach (sizes[j]) begin
      @(negedge clk);
      lp    = 4'(sizes[j]);
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
          n_errors++;
          $display("FAIL bad_size_%0d c%0d got busy=%0b done=%0b rd=%0b exp 0",
                   sizes[j], c, busy, done, rd_en);
        end
      end
    end
  endtask

  // P=3: stage 1 drains in cycles 5 and 6; reset sampled at the end of cycle 5.
  task automatic test_reset_mid();
    @(negedge clk);
    lp    = 4'd3;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = (c == 5);
      if (c <= 5) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++;
          $display("FAIL reset_mid busy c%0d got %0b exp 1", c, busy);
        end
      end else begin
        n_checks++;
        if ({busy, done, stage, stride, rd_en, rd_a1, rd_a2, wr_en, wr_a1, wr_a2} !== '0) begin
          n_errors++;
          $display("FAIL reset_mid c%0d got busy=%0b stage=%0d stride=%0d rd=%0b wr=%0b exp all 0",
                   c, busy, stage, stride, rd_en, wr_en);
        end
      end
    end
    rst = 1'b0;
    run_transform("after_reset", 3, 0, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    run_transform("p3_basic", 3, 0, 0, -1, -1);
    run_transform("p4_basic", 4, 0, 0, -1, -1);
    run_transform("p5_basic", 5, 0, 0, -1, -1);
    run_transform("p5_stall", 5, 14, 3, -1, -1);
    test_bad_size();
    test_reset_mid();
    run_transform("start_ignored", 3, 0, 0, 4, 10);
    run_transform("back_to_back", 6, 0, 0, -1, -1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
